// File: rtl/dma_pkg.sv
// Shared DMA definitions used by the PL-to-DDR stream path.
//   FRAME_LEN_W        : width of frame length / beat counts (matches the
//                        stream master's count port)
//   DEFAULT_DATA_WIDTH : default sample/beat width
package dma_pkg;
    localparam int FRAME_LEN_W        = 26;
    localparam int DEFAULT_DATA_WIDTH = 32;
endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   wr_en, wr_data     : push request (ignored while full)
//   rd_en              : pop request (ignored while empty)
//   head               : registered head word, valid while level != 0
//   level              : words stored (ADDR_WIDTH+1 bits, tells full from empty)
//   full               : level == DEPTH
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] head,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  full
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  wr_fire, rd_fire;

    assign full    = (level_q == (ADDR_WIDTH+1)'(DEPTH));
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && (level_q != '0);
    assign rd_nxt  = rd_ptr_q + ADDR_WIDTH'(1);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (rd_fire) rd_ptr_d = rd_nxt;
        case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
            2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
            default: level_d = level_q;
        endcase
        // The head register must always mirror mem[rd_ptr]. A word being
        // written this cycle is not yet in mem, so it is forwarded when it
        // becomes the new head (empty FIFO, or popping the only stored word).
        if (rd_fire)
            head_d = (level_q == (ADDR_WIDTH+1)'(1)) ? wr_data : mem[rd_nxt];
        else if (wr_fire && level_q == '0)
            head_d = wr_data;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr_q] <= wr_data;
    end

    assign head  = head_q;
    assign level = level_q;
endmodule

// File: rtl/stream_frame_buffer.sv
// Buffers producer samples and releases them as one unbroken frame once
// frame_len words are stored, so the downstream stream master never starves.
// Ports:
//   clk, resetn             : clock, synchronous active-low reset
//   frame_len               : words per frame, sampled at frame release
//   s_valid/s_data/s_ready  : producer side (s_ready = FIFO not full)
//   m_valid/m_data/m_ready  : beat side toward the stream master
//   m_start, m_last         : first / final beat markers
//   frame_done              : one-cycle pulse after final beat accepted
//   level                   : words currently stored
//   cfg_err                 : sticky, invalid frame_len seen while waiting
module stream_frame_buffer
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [FRAME_LEN_W-1:0] frame_len,
    input  logic                   s_valid,
    input  logic [DATA_WIDTH-1:0]  s_data,
    output logic                   s_ready,
    output logic                   m_valid,
    output logic [DATA_WIDTH-1:0]  m_data,
    input  logic                   m_ready,
    output logic                   m_start,
    output logic                   m_last,
    output logic                   frame_done,
    output logic [ADDR_WIDTH:0]    level,
    output logic                   cfg_err
);
    localparam int                     DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [FRAME_LEN_W-1:0] DEPTH_L = FRAME_LEN_W'(DEPTH);

    typedef enum logic {ST_WAIT, ST_STREAM} state_e;

    state_e                 state_q, state_d;
    logic [FRAME_LEN_W-1:0] len_q, len_d, beat_q, beat_d, level_ext;
    logic                   cfg_err_q, cfg_err_d, frame_done_q, frame_done_d;
    logic                   full, beat_last;

    sync_fifo_fwft #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .wr_en  (s_valid && s_ready),
        .wr_data(s_data),
        .rd_en  (m_valid && m_ready),
        .head   (m_data),
        .level  (level),
        .full   (full)
    );

    assign s_ready   = !full;
    assign level_ext = FRAME_LEN_W'(level);
    assign m_valid   = (state_q == ST_STREAM);
    assign beat_last = (beat_q == len_q - FRAME_LEN_W'(1));
    assign m_start   = m_valid && (beat_q == '0);
    assign m_last    = m_valid && beat_last;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        beat_d       = beat_q;
        cfg_err_d    = cfg_err_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (frame_len == '0 || frame_len > DEPTH_L) begin
                    cfg_err_d = 1'b1;
                end else if (level_ext >= frame_len) begin
                    state_d = ST_STREAM;
                    len_d   = frame_len;
                    beat_d  = '0;
                end
            end
            ST_STREAM: begin
                // The whole frame is already buffered, so every ready cycle pops.
                if (m_ready) begin
                    beat_d = beat_q + FRAME_LEN_W'(1);
                    if (beat_last) begin
                        state_d      = ST_WAIT;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_WAIT;
            len_q        <= '0;
            beat_q       <= '0;
            cfg_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            cfg_err_q    <= cfg_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign cfg_err    = cfg_err_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_stream_frame_buffer.sv
// Directed bench for stream_frame_buffer with a 16-deep FIFO.
module tb_stream_frame_buffer;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [25:0]   frame_len;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;
    logic          m_start;
    logic          m_last;
    logic          frame_done;
    logic [AW:0]   level;
    logic          cfg_err;

    int n_vec = 0;
    int n_err = 0;

    stream_frame_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .frame_len (frame_len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .m_start   (m_start),
        .m_last    (m_last),
        .frame_done(frame_done),
        .level     (level),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn  = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic wr_word(input logic [DW-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int k, wrote, popped;
        logic acc_w, acc_p;
        logic [AW:0] lvl_s;
        frame_len = 26'd4;
        s_data    = '0;
        do_reset();

        // reset state (sampled while resetn still low)
        resetn = 1'b0;
        tick();
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_start", 32'(m_start), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        resetn = 1'b1;

        // basic 4-word frame
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) wr_word(32'hA0 + 32'(i));
        chk("basic_level4", 32'(level), 32'd4);
        chk("basic_no_valid_t1", 32'(m_valid), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("basic_valid", 32'(m_valid), 32'd1);
            chk("basic_data", m_data, 32'hA0 + 32'(i));
            chk("basic_start", 32'(m_start), 32'(i == 0));
            chk("basic_last", 32'(m_last), 32'(i == 3));
            tick();
        end
        chk("basic_done", 32'(frame_done), 32'd1);
        chk("basic_valid_off", 32'(m_valid), 32'd0);
        chk("basic_level0", 32'(level), 32'd0);
        tick();
        chk("basic_done_pulse", 32'(frame_done), 32'd0);

        // backpressure, m_ready toggling
        do_reset();
        frame_len = 26'd8;
        for (int i = 0; i < 8; i++) wr_word(32'hB0 + 32'(i));
        tick();
        k = 0;
        for (int c = 0; c < 16; c++) begin
            m_ready = c[0];
            chk("bp_valid", 32'(m_valid), 32'd1);
            chk("bp_data", m_data, 32'hB0 + 32'(k));
            chk("bp_start", 32'(m_start), 32'(k == 0));
            chk("bp_last", 32'(m_last), 32'(k == 7));
            if (m_ready) k++;
            tick();
        end
        chk("bp_beats", 32'(k), 32'd8);
        chk("bp_done", 32'(frame_done), 32'd1);
        chk("bp_level0", 32'(level), 32'd0);

        // full FIFO: 20 words offered with frame_len=16
        do_reset();
        frame_len = 26'd16;
        s_valid   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_data = 32'h100 + 32'(i);
            tick();
        end
        chk("full_level16", 32'(level), 32'd16);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        wrote   = 16;
        popped  = 0;
        m_ready = 1'b1;
        for (int c = 0; c < 40 && popped < 16; c++) begin
            s_valid = (wrote < 20);
            s_data  = 32'h100 + 32'(wrote);
            acc_w   = s_valid && s_ready;
            acc_p   = m_valid && m_ready;
            if (m_valid) begin
                chk("full_data", m_data, 32'h100 + 32'(popped));
                chk("full_start", 32'(m_start), 32'(popped == 0));
                chk("full_last", 32'(m_last), 32'(popped == 15));
            end
            tick();
            wrote  += int'(acc_w);
            popped += int'(acc_p);
        end
        s_valid = 1'b0;
        chk("full_popped16", 32'(popped), 32'd16);
        chk("full_wrote20", 32'(wrote), 32'd20);
        chk("full_level4", 32'(level), 32'd4);
        chk("full_done", 32'(frame_done), 32'd1);
        tick();
        chk("full_hold", 32'(m_valid), 32'd0);
        frame_len = 26'd4;
        for (int c = 0; c < 20 && popped < 20; c++) begin
            acc_p = m_valid;
            if (m_valid) begin
                chk("rem_data", m_data, 32'h100 + 32'(popped));
                chk("rem_start", 32'(m_start), 32'(popped == 16));
                chk("rem_last", 32'(m_last), 32'(popped == 19));
            end
            tick();
            popped += int'(acc_p);
        end
        chk("rem_popped20", 32'(popped), 32'd20);
        chk("rem_level0", 32'(level), 32'd0);

        // concurrent write/pop, continuous producer
        do_reset();
        frame_len = 26'd4;
        m_ready   = 1'b1;
        s_valid   = 1'b1;
        wrote     = 0;
        popped    = 0;
        lvl_s     = '0;
        for (int c = 0; c < 40; c++) begin
            s_data = 32'hD00 + 32'(wrote);
            acc_w  = s_ready;
            acc_p  = m_valid;
            if (m_valid) begin
                chk("cc_data", m_data, 32'hD00 + 32'(popped));
                chk("cc_start", 32'(m_start), 32'(popped % 4 == 0));
                chk("cc_last", 32'(m_last), 32'(popped % 4 == 3));
                if (m_start) lvl_s = level;
                else chk("cc_level_const", 32'(level), 32'(lvl_s));
            end
            tick();
            wrote  += int'(acc_w);
            popped += int'(acc_p);
        end
        s_valid = 1'b0;
        chk("cc_popped", 32'(popped), 32'd28);

        // config errors
        do_reset();
        frame_len = 26'd0;
        tick();
        chk("cfg_zero", 32'(cfg_err), 32'd1);
        chk("cfg_zero_valid", 32'(m_valid), 32'd0);
        do_reset();
        chk("cfg_cleared", 32'(cfg_err), 32'd0);
        frame_len = 26'd17;
        wr_word(32'hE0);
        wr_word(32'hE1);
        tick();
        chk("cfg_big", 32'(cfg_err), 32'd1);
        chk("cfg_big_valid", 32'(m_valid), 32'd0);
        chk("cfg_big_level", 32'(level), 32'd2);
        frame_len = 26'd2;
        m_ready   = 1'b1;
        tick();
        chk("cfg_rel_valid", 32'(m_valid), 32'd1);
        chk("cfg_rel_data0", m_data, 32'hE0);
        chk("cfg_rel_start", 32'(m_start), 32'd1);
        tick();
        chk("cfg_rel_data1", m_data, 32'hE1);
        chk("cfg_rel_last", 32'(m_last), 32'd1);
        tick();
        chk("cfg_rel_done", 32'(frame_done), 32'd1);
        chk("cfg_sticky", 32'(cfg_err), 32'd1);

        // reset mid-frame
        do_reset();
        frame_len = 26'd8;
        m_ready   = 1'b1;
        for (int i = 0; i < 8; i++) wr_word(32'hF0 + 32'(i));
        tick();
        tick();
        tick();
        chk("mid_beat3", m_data, 32'hF2);
        resetn = 1'b0;
        tick();
        chk("mid_valid", 32'(m_valid), 32'd0);
        chk("mid_level", 32'(level), 32'd0);
        chk("mid_s_ready", 32'(s_ready), 32'd1);
        resetn    = 1'b1;
        frame_len = 26'd4;
        for (int i = 0; i < 4; i++) wr_word(32'h50 + 32'(i));
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("post_valid", 32'(m_valid), 32'd1);
            chk("post_data", m_data, 32'h50 + 32'(i));
            chk("post_start", 32'(m_start), 32'(i == 0));
            chk("post_last", 32'(m_last), 32'(i == 3));
            tick();
        end
        chk("post_done", 32'(frame_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/stream_frame_buffer.md
# stream_frame_buffer

Upstream feeder for the PL-to-DDR AXI-Stream master. It absorbs bursty samples from the data producer into an on-chip FIFO and releases them as one unbroken frame only after `frame_len` words are buffered. The downstream stream master can therefore pop one word on every ready cycle without starving. It also generates the frame-start pulse and the last-beat marker.

## Interface
Parameters:
- `DATA_WIDTH`, 32, sample/beat width
- `ADDR_WIDTH`, 10, FIFO address width; depth `DEPTH = 2**ADDR_WIDTH`

Ports:
- Clock and reset: clock `clk`; reset `resetn`, synchronous, active-low.
- `clk`  in  1  clock
- `resetn`  in  1  synchronous active-low reset
- `frame_len`  in  26  words per frame; sampled when a frame is released
- `s_valid`  in  1  producer word valid
- `s_data`  in  DATA_WIDTH  producer word
- `s_ready`  out  1  FIFO not full
- `m_valid`  out  1  beat valid toward stream master
- `m_data`  out  DATA_WIDTH  beat data (FIFO head)
- `m_ready`  in  1  stream master accepts beat
- `m_start`  out  1  high with first beat of a frame
- `m_last`  out  1  high with final beat of a frame
- `frame_done`  out  1  one-cycle pulse after final beat accepted
- `level`  out  ADDR_WIDTH+1  words currently stored
- `cfg_err`  out  1  sticky: frame_len==0 or frame_len>DEPTH seen in WAIT

## Operation
- Write: occurs when `s_valid && s_ready`. `s_ready = (level != DEPTH)`.
- Pop: occurs when `m_valid && m_ready`.
- FSM has two states:
  - WAIT: `m_valid=0`. Moves to STREAM when `1 <= frame_len <= DEPTH` and `level >= frame_len`. On that transition, `frame_len` is latched into `len_q` and the beat counter `beat` is cleared.
  - STREAM: `m_valid=1` for the whole frame, with no bubbles, since the frame is fully buffered. Each pop increments `beat`.
    - `m_start = m_valid && beat==0`.
    - `m_last = m_valid && beat==len_q-1`.
    - Popping the last beat returns the FSM to WAIT and pulses `frame_done` on the next cycle.
- `frame_len` changes during STREAM have no effect; the next frame uses the value sampled at its own release.
- Invalid `frame_len` (0 or >DEPTH) in WAIT: FSM stays in WAIT and sets `cfg_err`. Only reset clears `cfg_err`.
- Writes continue during STREAM. A simultaneous write and pop leaves `level` unchanged.
- Pointers wrap modulo DEPTH. `level` distinguishes full from empty.
- Length arithmetic: `beat` and `len_q` are 26 bits. Comparisons are unsigned, with `level` zero-extended to 26 bits.
- Reset mid-frame: pointers, level, `beat`, state and flags all clear immediately. Buffered data is discarded.

## Timing
- Reset values: `s_ready=1`, `m_valid=0`, `m_start=0`, `m_last=0`, `frame_done=0`, `level=0`, `cfg_err=0`. `m_data` is don't-care while `m_valid=0`.
- `level` updates one cycle after a write or pop handshake.
- Release latency: the write that makes `level>=frame_len` is at cycle t. `level` updates at t+1, the FSM enters STREAM at t+2, and `m_valid` is high from t+2.
- `m_data` is the registered FIFO head (first-word-fall-through). The next word is presented the cycle after a pop.
- Throughput: 1 beat/cycle in STREAM while `m_ready=1`. `m_valid` and `m_data` hold stable while `m_ready=0`.
- `frame_done` asserts exactly one cycle after the cycle in which `m_last` beat popped.
- Back-to-back frames: if enough words are already buffered, the next frame releases 1 cycle after re-entering WAIT.

## Structure
- Shared package/header `dma_pkg` holds:
  - `FRAME_LEN_W = 26`, shared with the stream master's count port.
  - Default `DATA_WIDTH`.
- FSM state encoding stays local to this block.
- Sub-module `sync_fifo_fwft` (DATA_WIDTH, ADDR_WIDTH): memory, pointers, level, registered head.
- The top level contains the FSM, beat counter, `cfg_err` and the start/last/done decode.

## Test plan
- Basic frame: `frame_len=4`, write 0xA0..0xA3 on back-to-back cycles, `m_ready=1`.
  - `m_valid` rises 2 cycles after the 4th write.
  - Beats are 0xA0..0xA3 with `m_start` on 0xA0 and `m_last` on 0xA3.
  - `frame_done` pulses 1 cycle later and `level` returns to 0.
- Backpressure: `frame_len=8`, toggle `m_ready` every other cycle.
  - 8 beats arrive in order.
  - `m_data` is stable while `m_ready=0`.
  - `m_valid` never drops mid-frame.
- Full FIFO: `ADDR_WIDTH=4`, write 20 words with `frame_len=16`.
  - `s_ready` falls at `level=16`.
  - After the frame drains, the remaining 4 words are accepted.
  - No word is lost or duplicated.
- Concurrent write/pop: `frame_len=4` with the producer writing continuously.
  - `level` stays constant during STREAM.
  - Consecutive frames are delivered with `m_start`/`m_last` correctly marked.
- Config error: `frame_len=0`, then `frame_len=DEPTH+1`.
  - `cfg_err=1` and `m_valid` stays 0.
  - Setting `frame_len=2` then releases a frame normally, and `cfg_err` remains 1.
- Reset mid-frame: assert `resetn=0` on beat 3 of 8.
  - Next cycle shows `m_valid=0`, `level=0`, `s_ready=1`.
  - A fresh 4-word frame afterwards starts with `m_start` on the first word written.
